// File: rtl/mips_test_sequencer_pkg.sv
// Shared definitions for the MIPS self-test sequencer: FSM state encoding,
// test index width and the store comparison helper.
package mips_test_sequencer_pkg;

    localparam int TEST_IDX_W = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RST   = 3'd1,
        S_RUN   = 3'd2,
        S_SCORE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // A store matches only when both address and data agree with the table.
    function automatic logic store_match(input logic [31:0] adr,
                                         input logic [31:0] data,
                                         input logic [31:0] exp_adr,
                                         input logic [31:0] exp_data);
        return (adr == exp_adr) && (data == exp_data);
    endfunction

endpackage

// File: rtl/mips_test_sequencer_store_matcher.sv
// Store matcher: compares each sampled core store against the expected
// address/data, keeps a sticky hit flag and a saturating mismatch counter.
module store_matcher
    import mips_test_sequencer_pkg::*;
#(
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              memwrite_i,
    input  logic [31:0]       dataadr_i,
    input  logic [31:0]       writedata_i,
    input  logic [31:0]       exp_adr_i,
    input  logic [31:0]       exp_data_i,
    output logic              hit_o,
    output logic [MISS_W-1:0] miss_count_o
);

    logic              hit_q,  hit_d;
    logic [MISS_W-1:0] miss_q, miss_d;

    // Clear wins over sampling; a miss stops counting once all ones.
    always_comb begin
        hit_d  = hit_q;
        miss_d = miss_q;
        if (clr_i) begin
            hit_d  = 1'b0;
            miss_d = '0;
        end else if (en_i && memwrite_i) begin
            if (store_match(dataadr_i, writedata_i, exp_adr_i, exp_data_i)) begin
                hit_d = 1'b1;
            end else if (!(&miss_q)) begin
                miss_d = miss_q + MISS_W'(1);
            end
        end
    end

    // Hit flag and mismatch counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q  <= 1'b0;
            miss_q <= '0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    assign hit_o        = hit_q;
    assign miss_count_o = miss_q;

endmodule

// File: rtl/mips_test_sequencer.sv
// MIPS self-test sequencer: runs NUM_TESTS programs back to back, holding
// the core in reset briefly before each, watching its store bus for a fixed
// window and scoring each test against an external expected-store table.
module mips_test_sequencer
    import mips_test_sequencer_pkg::*;
#(
    parameter int NUM_TESTS     = 10,
    parameter int RESET_CYCLES  = 2,
    parameter int WINDOW_CYCLES = 98,
    parameter int MISS_W        = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  memwrite,
    input  logic [31:0]           dataadr,
    input  logic [31:0]           writedata,
    input  logic [31:0]           exp_adr,
    input  logic [31:0]           exp_data,
    output logic                  cpu_reset,
    output logic [TEST_IDX_W-1:0] test_idx,
    output logic                  test_done,
    output logic                  test_pass,
    output logic [4:0]            pass_count,
    output logic [MISS_W-1:0]     miss_count,
    output logic                  busy,
    output logic                  all_done
);

    // One counter serves both the reset hold and the run window.
    localparam int CNT_MAX = (WINDOW_CYCLES > RESET_CYCLES) ? WINDOW_CYCLES : RESET_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]      RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]      WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [TEST_IDX_W-1:0] IDX_LAST = TEST_IDX_W'(NUM_TESTS - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q,   cnt_d;
    logic [TEST_IDX_W-1:0]   idx_q,   idx_d;
    logic [4:0]              pass_q,  pass_d;
    logic                    clr;
    logic                    hit;

    // Next-state, counters and pass accounting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        clr     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RST;
                    cnt_d   = '0;
                    idx_d   = '0;
                    pass_d  = '0;
                    clr     = 1'b1;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == WIN_LAST) begin
                    state_d = S_SCORE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SCORE: begin
                pass_d = pass_q + {4'b0000, hit};
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + TEST_IDX_W'(1);
                    clr     = 1'b1;
                    state_d = S_RST;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
        end
    end

    store_matcher #(
        .MISS_W (MISS_W)
    ) u_matcher (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (clr),
        .en_i         (state_q == S_RUN),
        .memwrite_i   (memwrite),
        .dataadr_i    (dataadr),
        .writedata_i  (writedata),
        .exp_adr_i    (exp_adr),
        .exp_data_i   (exp_data),
        .hit_o        (hit),
        .miss_count_o (miss_count)
    );

    assign cpu_reset  = (state_q != S_RUN);
    assign test_idx   = idx_q;
    assign test_done  = (state_q == S_SCORE);
    assign test_pass  = (state_q == S_SCORE) && hit;
    assign pass_count = pass_q;
    assign busy       = (state_q == S_RST) || (state_q == S_RUN) || (state_q == S_SCORE);
    assign all_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Bench for mips_test_sequencer: a stub core presents stores on a timeline
// relative to the start pulse; a timeline/table model predicts every output.
module tb_mips_test_sequencer;

    localparam int N      = 10;
    localparam int R      = 2;
    localparam int W      = 98;
    localparam int MISS_W = 6;
    localparam int P      = R + W + 1;
    localparam int MAXM   = (1 << MISS_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              memwrite = 1'b0;
    logic [31:0]       dataadr = '0;
    logic [31:0]       writedata = '0;
    logic [31:0]       exp_adr;
    logic [31:0]       exp_data;
    logic              cpu_reset;
    logic [3:0]        test_idx;
    logic              test_done;
    logic              test_pass;
    logic [4:0]        pass_count;
    logic [MISS_W-1:0] miss_count;
    logic              busy;
    logic              all_done;

    logic [31:0] tab_a [N];
    logic [31:0] tab_d [N];
    int          hit_m [N];
    int          miss_m [N];
    int          n_assert = 0;
    int          n_fail = 0;
    int          last_pass;

    // Asynchronous expected-store table, indexed by the current test.
    assign exp_adr  = tab_a[test_idx];
    assign exp_data = tab_d[test_idx];

    mips_test_sequencer #(
        .NUM_TESTS     (N),
        .RESET_CYCLES  (R),
        .WINDOW_CYCLES (W),
        .MISS_W        (MISS_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .exp_adr    (exp_adr),
        .exp_data   (exp_data),
        .cpu_reset  (cpu_reset),
        .test_idx   (test_idx),
        .test_done  (test_done),
        .test_pass  (test_pass),
        .pass_count (pass_count),
        .miss_count (miss_count),
        .busy       (busy),
        .all_done   (all_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int t, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s [test %0d]: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Stub core: what store (and start pulse) to present before edge offset o of test t.
    task automatic gen(input int scen, input int t, input int o,
                       output logic mw, output logic [31:0] a, output logic [31:0] d, output logic st);
        mw = 1'b0; a = $urandom; d = $urandom; st = 1'b0;
        case (scen)
            1: if (t == 0 && o == R + 40) begin mw = 1'b1; a = 32'd18; d = 32'd21; end
            2: if (t == 0 && o == R + 17) begin mw = 1'b1; a = 32'd84; d = 32'd6; end
            3: begin
                if (t % 2 == 0 && o == R + 5 + 7 * t) begin mw = 1'b1; a = tab_a[t]; d = tab_d[t]; end
                if (t == 1 && o == 50) st = 1'b1;
            end
            4: begin
                if (t == 0 && o == R + W - 1) begin mw = 1'b1; a = tab_a[0]; d = tab_d[0]; end
                else if (t == 1 && o == R + W) begin mw = 1'b1; a = tab_a[1]; d = tab_d[1]; end
                else if (t == 2 && o < R) begin mw = 1'b1; a = tab_a[2]; d = tab_d[2]; end
                else if (t >= 3) begin
                    mw = ($urandom_range(0, 3) == 0);
                    if ($urandom_range(0, 7) == 0) begin a = tab_a[t]; d = tab_d[t]; end
                end
            end
            5: begin
                if (t == 0 && o >= R && o <= R + W - 2) begin mw = 1'b1; a = tab_a[0] ^ 32'h1; d = tab_d[0]; end
                else if (t == 0 && o == R + W - 1) begin mw = 1'b1; a = tab_a[0]; d = tab_d[0]; end
                else if (t >= 2) mw = ($urandom_range(0, 3) == 0);
            end
            default: begin
                mw = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 5) == 0) begin a = tab_a[t]; d = tab_d[t]; end
                st = ($urandom_range(0, 63) == 0);
            end
        endcase
    endtask

    // One full sequence from a start pulse; abort_k>0 asserts reset before that edge.
    task automatic run_seq(input int scen, input int abort_k);
        int          t, o, passes;
        logic        mw, st;
        logic [31:0] a, d;
        for (int i = 0; i < N; i++) begin
            tab_a[i] = $urandom; tab_d[i] = $urandom; hit_m[i] = 0; miss_m[i] = 0;
        end
        if (scen == 1) begin tab_a[0] = 32'd18; tab_d[0] = 32'd21; end
        if (scen == 2) begin tab_a[0] = 32'd84; tab_d[0] = 32'd7; end
        if (scen == 3) begin
            tab_a[0] = 32'h70f00ff0; tab_d[0] = 32'd2;
            tab_a[2] = 32'h0000000c; tab_d[2] = 32'h12;
        end
        passes = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("start_busy", 0, busy, 1);
        check("start_all_done", 0, all_done, 0);
        check("start_idx", 0, test_idx, 0);
        check("start_pass_count", 0, pass_count, 0);
        check("start_miss", 0, miss_count, 0);
        for (int k = 1; k <= N * P; k++) begin
            t = (k - 1) / P;
            o = (k - 1) % P;
            gen(scen, t, o, mw, a, d, st);
            @(negedge clk);
            memwrite = mw; dataadr = a; writedata = d; start = st;
            if (k == abort_k) begin
                #1 reset = 1'b1;
                #1;
                check("abort_cpu_reset", t, cpu_reset, 1);
                check("abort_idx", t, test_idx, 0);
                check("abort_busy", t, busy, 0);
                check("abort_pass_count", t, pass_count, 0);
                check("abort_miss", t, miss_count, 0);
                check("abort_done", t, test_done, 0);
                @(posedge clk); #1;
                check("abort_done_held", t, test_done, 0);
                check("abort_all_done", t, all_done, 0);
                @(negedge clk);
                reset = 1'b0; memwrite = 1'b0; start = 1'b0;
                return;
            end
            if (mw && o >= R && o <= R + W - 1) begin
                if (a == tab_a[t] && d == tab_d[t]) hit_m[t] = 1;
                else if (miss_m[t] < MAXM) miss_m[t]++;
            end
            @(posedge clk); #1;
            check("cpu_reset", t, cpu_reset, (o >= R - 1 && o <= R + W - 2) ? 0 : 1);
            check("test_done", t, test_done, (o == R + W - 1) ? 1 : 0);
            check("miss_count", t, miss_count, (o == P - 1 && t < N - 1) ? 0 : miss_m[t]);
            if (o == R + W - 1) begin
                check("test_pass", t, test_pass, hit_m[t]);
                check("score_idx", t, test_idx, t);
            end
            if (o == P - 1) begin
                passes += hit_m[t];
                check("pass_count", t, pass_count, passes);
                if (t < N - 1) begin
                    check("next_idx", t, test_idx, t + 1);
                    check("busy", t, busy, 1);
                end else begin
                    check("all_done", t, all_done, 1);
                    check("busy_end", t, busy, 0);
                end
            end
        end
        memwrite = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("done_level", 0, all_done, 1);
        check("done_cpu_reset", 0, cpu_reset, 1);
        last_pass = passes;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_reset", 0, cpu_reset, 1);
        check("rst_idx", 0, test_idx, 0);
        check("rst_done", 0, test_done, 0);
        check("rst_pass", 0, test_pass, 0);
        check("rst_pass_count", 0, pass_count, 0);
        check("rst_miss", 0, miss_count, 0);
        check("rst_busy", 0, busy, 0);
        check("rst_all_done", 0, all_done, 0);
        @(negedge clk); reset = 1'b0;
        // Stores while idle must be ignored.
        memwrite = 1'b1; dataadr = 32'h5; writedata = 32'h6;
        @(posedge clk); #1;
        check("idle_miss", 0, miss_count, 0);
        check("idle_busy", 0, busy, 0);
        memwrite = 1'b0;

        run_seq(1, 0);
        check("scen1_total", 0, pass_count, 1);
        run_seq(2, 0);
        check("scen2_total", 0, pass_count, 0);
        run_seq(3, 0);
        check("scen3_total", 0, pass_count, 5);
        run_seq(4, 0);
        run_seq(5, 0);
        run_seq(6, 0);
        run_seq(6, 3 * P + R + 21);
        run_seq(3, 0);
        check("rerun_total", 0, pass_count, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
